// File: rtl/ups_mode_if.sv
// Mode-switch bundle between the operator switch front end and the mode controller.
// The controller side takes the slave modport; the switch/stimulus side takes master.
interface ups_mode_if #(
   parameter int MODE_W = 2
);
   logic [MODE_W-1:0] mode_sw;
   logic [MODE_W-1:0] mode;
   logic              mode_change;
   logic              mode_err;

   modport master (output mode_sw, input mode, mode_change, mode_err);
   modport slave  (input mode_sw, output mode, mode_change, mode_err);
endinterface

// File: rtl/ups_mode_ctrl.sv
// Synchronizes and debounces the UPS mode switch, commits legal modes and emits a
// fixed-width mode_change pulse per commit; an illegal code sets a sticky error.
//
// state  | meaning
// IDLE   | candidate matches synchronized switch, waiting for a change
// FILTER | counting consecutive stable cycles of the candidate
// PULSE  | new mode committed, holding mode_change high
module ups_mode_ctrl #(
   parameter int MODE_W       = 2,
   parameter int DEBOUNCE_CYC = 1000,
   parameter int PULSE_CYC    = 4,
   parameter int RESET_MODE   = 0,
   parameter int ILLEGAL_MODE = 3
) (
   input  logic           clk,
   input  logic           rst,
   ups_mode_if.slave      ctrl_io
);

   localparam int CNT_W  = $clog2(DEBOUNCE_CYC);
   localparam int PCNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

   localparam logic [MODE_W-1:0] RST_M    = MODE_W'(RESET_MODE);
   localparam logic [MODE_W-1:0] ILL_M    = MODE_W'(ILLEGAL_MODE);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PULSE_CYC - 1);

   typedef enum logic [1:0] {IDLE, FILTER, PULSE} state_t;

   state_t              state_q;
   logic [MODE_W-1:0]   sync1_q;
   logic [MODE_W-1:0]   sync2_q;
   logic [MODE_W-1:0]   cand_q;
   logic [MODE_W-1:0]   mode_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [PCNT_W-1:0]   pcnt_q;
   logic                chg_q;
   logic                err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sync1_q <= RST_M;
         sync2_q <= RST_M;
         cand_q  <= RST_M;
         mode_q  <= RST_M;
         cnt_q   <= '0;
         pcnt_q  <= '0;
         chg_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync1_q <= ctrl_io.mode_sw;
         sync2_q <= sync1_q;
         case (state_q)
            IDLE: begin
               if (sync2_q != cand_q) begin
                  cand_q  <= sync2_q;
                  cnt_q   <= '0;
                  state_q <= FILTER;
               end
            end
            FILTER: begin
               if (sync2_q != cand_q) begin
                  cand_q <= sync2_q;
                  cnt_q  <= '0;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_q + 1'b1;
               end else if (cand_q == mode_q) begin
                  state_q <= IDLE;
               end else if (cand_q == ILL_M) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  mode_q  <= cand_q;
                  chg_q   <= 1'b1;
                  pcnt_q  <= '0;
                  state_q <= PULSE;
               end
            end
            PULSE: begin
               // Switch is ignored here; any change is caught from IDLE, which
               // guarantees a full debounce window of low time between pulses.
               if (pcnt_q == PCNT_MAX) begin
                  chg_q   <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  pcnt_q <= pcnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ctrl_io.mode        = mode_q;
   assign ctrl_io.mode_change = chg_q;
   assign ctrl_io.mode_err    = err_q;

endmodule

// File: tb/tb_ups_mode_ctrl.sv
// Scoreboard bench for ups_mode_ctrl: expected pulses are queued at stimulus time and
// compared against pulses captured by a negedge monitor.
module tb_ups_mode_ctrl;

   localparam int DB = 8;
   localparam int PC = 4;

   typedef struct {
      int         cyc;
      logic [1:0] mode;
      logic       err;
      int         width;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   bit   in_p = 1'b0;
   bit   bad_mode = 1'b0;
   ev_t  cur, e, o;
   ev_t  exp_q[$];
   ev_t  obs_q[$];

   ups_mode_if #(.MODE_W(2)) bus ();

   ups_mode_ctrl #(
      .MODE_W(2), .DEBOUNCE_CYC(DB), .PULSE_CYC(PC), .RESET_MODE(0), .ILLEGAL_MODE(3)
   ) dut (
      .clk(clk), .rst(rst), .ctrl_io(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Records each mode_change pulse: edge of rise, mode/err at rise, width in cycles.
   always @(negedge clk) begin
      if (rst) begin
         in_p = 1'b0;
      end else begin
         if (bus.mode === 2'd3) bad_mode = 1'b1;
         if (bus.mode_change === 1'b1) begin
            if (!in_p) begin
               in_p = 1'b1;
               cur.cyc = cyc; cur.mode = bus.mode; cur.err = bus.mode_err; cur.width = 1;
            end else begin
               cur.width++;
            end
         end else if (in_p) begin
            in_p = 1'b0;
            obs_q.push_back(cur);
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.mode_sw = 2'd0;
      repeat (3) @(negedge clk);
      exp_q.delete();
      obs_q.delete();
      rst = 1'b0;
   endtask

   task automatic push_exp(input int c, input logic [1:0] m, input logic er);
      ev_t t;
      t.cyc = c; t.mode = m; t.err = er; t.width = PC;
      exp_q.push_back(t);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.mode_sw = 2'd0;
      #2;
      n_vec++;
      if ({bus.mode, bus.mode_change, bus.mode_err} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_state: got mode=%0d chg=%0b err=%0b, want 0/0/0",
                  bus.mode, bus.mode_change, bus.mode_err);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         n_vec++;
         if ({bus.mode, bus.mode_change, bus.mode_err} !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_hold cycle %0d: got mode=%0d chg=%0b err=%0b, want 0/0/0",
                     i, bus.mode, bus.mode_change, bus.mode_err);
         end
      end
   endtask

   task automatic test_clean_change();
      do_reset();
      push_exp(cyc + DB + 3, 2'd2, 1'b0);
      bus.mode_sw = 2'd2;
      repeat (25) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL clean_pulse: got no pulse, want mode=%0d at cycle %0d", e.mode, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.mode !== e.mode || o.err !== e.err || o.width !== e.width) begin
               n_err++;
               $display("FAIL clean_pulse: got cyc=%0d mode=%0d err=%0b w=%0d, want cyc=%0d mode=%0d err=%0b w=%0d",
                        o.cyc, o.mode, o.err, o.width, e.cyc, e.mode, e.err, e.width);
            end
         end
      end
      n_vec++;
      if (obs_q.size() != 0 || bus.mode !== 2'd2 || bus.mode_err !== 1'b0) begin
         n_err++;
         $display("FAIL clean_final: got extra=%0d mode=%0d err=%0b, want 0/2/0",
                  obs_q.size(), bus.mode, bus.mode_err);
      end
   endtask

   task automatic test_bounce();
      do_reset();
      bus.mode_sw = 2'd1;
      repeat (5) @(negedge clk);
      bus.mode_sw = 2'd0;
      repeat (20) @(negedge clk);
      n_vec++;
      if (obs_q.size() != 0 || bus.mode !== 2'd0) begin
         n_err++;
         $display("FAIL bounce_reject: got pulses=%0d mode=%0d, want 0/0", obs_q.size(), bus.mode);
      end
      bus.mode_sw = 2'd1; repeat (2) @(negedge clk);
      bus.mode_sw = 2'd0; repeat (3) @(negedge clk);
      bus.mode_sw = 2'd1; repeat (1) @(negedge clk);
      bus.mode_sw = 2'd0; repeat (2) @(negedge clk);
      push_exp(cyc + DB + 3, 2'd1, 1'b0);
      bus.mode_sw = 2'd1;
      repeat (25) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL bounce_pulse: got no pulse, want mode=%0d at cycle %0d", e.mode, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.mode !== e.mode || o.err !== e.err || o.width !== e.width) begin
               n_err++;
               $display("FAIL bounce_pulse: got cyc=%0d mode=%0d err=%0b w=%0d, want cyc=%0d mode=%0d err=%0b w=%0d",
                        o.cyc, o.mode, o.err, o.width, e.cyc, e.mode, e.err, e.width);
            end
         end
      end
      n_vec++;
      if (obs_q.size() != 0 || bus.mode !== 2'd1) begin
         n_err++;
         $display("FAIL bounce_final: got extra=%0d mode=%0d, want 0/1", obs_q.size(), bus.mode);
      end
   endtask

   task automatic test_illegal();
      do_reset();
      bus.mode_sw = 2'd3;
      repeat (20) @(negedge clk);
      n_vec++;
      if (obs_q.size() != 0 || bus.mode !== 2'd0 || bus.mode_change !== 1'b0 || bus.mode_err !== 1'b1) begin
         n_err++;
         $display("FAIL illegal_reject: got pulses=%0d mode=%0d chg=%0b err=%0b, want 0/0/0/1",
                  obs_q.size(), bus.mode, bus.mode_change, bus.mode_err);
      end
      push_exp(cyc + DB + 3, 2'd1, 1'b1);
      bus.mode_sw = 2'd1;
      repeat (25) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL illegal_recover: got no pulse, want mode=%0d at cycle %0d", e.mode, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.mode !== e.mode || o.err !== e.err || o.width !== e.width) begin
               n_err++;
               $display("FAIL illegal_recover: got cyc=%0d mode=%0d err=%0b w=%0d, want cyc=%0d mode=%0d err=%0b w=%0d",
                        o.cyc, o.mode, o.err, o.width, e.cyc, e.mode, e.err, e.width);
            end
         end
      end
      n_vec++;
      if (bus.mode !== 2'd1 || bus.mode_err !== 1'b1) begin
         n_err++;
         $display("FAIL illegal_sticky: got mode=%0d err=%0b, want 1/1", bus.mode, bus.mode_err);
      end
   endtask

   task automatic test_back_to_back();
      int c0;
      ev_t first;
      do_reset();
      c0 = cyc;
      push_exp(c0 + DB + 3, 2'd1, 1'b0);
      bus.mode_sw = 2'd1;
      repeat (DB + 4) @(negedge clk);
      // Second cycle of the first pulse: the new code must wait for IDLE to be seen.
      bus.mode_sw = 2'd2;
      push_exp(c0 + DB + 3 + PC + 1 + DB, 2'd2, 1'b0);
      repeat (30) @(negedge clk);
      first.cyc = 0; first.width = 0;
      for (int k = 0; k < 2; k++) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL b2b_pulse%0d: got no pulse, want mode=%0d at cycle %0d", k, e.mode, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (k == 0) first = o;
            if (o.cyc !== e.cyc || o.mode !== e.mode || o.err !== e.err || o.width !== e.width) begin
               n_err++;
               $display("FAIL b2b_pulse%0d: got cyc=%0d mode=%0d err=%0b w=%0d, want cyc=%0d mode=%0d err=%0b w=%0d",
                        k, o.cyc, o.mode, o.err, o.width, e.cyc, e.mode, e.err, e.width);
            end
            n_vec++;
            if (k == 1 && (o.cyc - (first.cyc + first.width)) < DB) begin
               n_err++;
               $display("FAIL b2b_gap: got %0d low cycles, want at least %0d",
                        o.cyc - (first.cyc + first.width), DB);
            end
         end
      end
      n_vec++;
      if (obs_q.size() != 0 || bus.mode !== 2'd2) begin
         n_err++;
         $display("FAIL b2b_final: got extra=%0d mode=%0d, want 0/2", obs_q.size(), bus.mode);
      end
   endtask

   task automatic test_reset_mid_pulse();
      int cr;
      do_reset();
      bus.mode_sw = 2'd1;
      repeat (DB + 4) @(negedge clk);
      n_vec++;
      if (bus.mode_change !== 1'b1 || bus.mode !== 2'd1) begin
         n_err++;
         $display("FAIL rst_mid_pre: got chg=%0b mode=%0d, want 1/1", bus.mode_change, bus.mode);
      end
      #1 rst = 1'b1;
      #1;
      n_vec++;
      if (bus.mode_change !== 1'b0 || bus.mode !== 2'd0 || bus.mode_err !== 1'b0) begin
         n_err++;
         $display("FAIL rst_mid_async: got chg=%0b mode=%0d err=%0b, want 0/0/0",
                  bus.mode_change, bus.mode, bus.mode_err);
      end
      repeat (2) @(negedge clk);
      exp_q.delete();
      obs_q.delete();
      rst = 1'b0;
      cr = cyc;
      push_exp(cr + DB + 3, 2'd1, 1'b0);
      repeat (DB + 2) @(negedge clk);
      n_vec++;
      if (obs_q.size() != 0 || bus.mode_change !== 1'b0 || bus.mode !== 2'd0) begin
         n_err++;
         $display("FAIL rst_mid_quiet: got pulses=%0d chg=%0b mode=%0d, want 0/0/0",
                  obs_q.size(), bus.mode_change, bus.mode);
      end
      repeat (15) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_vec++;
         if (obs_q.size() == 0) begin
            n_err++;
            $display("FAIL rst_mid_recommit: got no pulse, want mode=%0d at cycle %0d", e.mode, e.cyc);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.mode !== e.mode || o.err !== e.err || o.width !== e.width) begin
               n_err++;
               $display("FAIL rst_mid_recommit: got cyc=%0d mode=%0d err=%0b w=%0d, want cyc=%0d mode=%0d err=%0b w=%0d",
                        o.cyc, o.mode, o.err, o.width, e.cyc, e.mode, e.err, e.width);
            end
         end
      end
      n_vec++;
      if (bad_mode) begin
         n_err++;
         $display("FAIL mode_legal: got illegal code 3 on mode, want never");
      end
   endtask

   initial begin
      bus.mode_sw = 2'd0;
      test_reset();
      test_clean_change();
      test_bounce();
      test_illegal();
      test_back_to_back();
      test_reset_mid_pulse();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
